// File: rtl/md_pkg.sv
// md_pkg: op encodings, FSM state type and default latencies shared by the MD issue controller.
package md_pkg;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W = 8;
    localparam logic [2:0] MD_NONE = 3'd0;
    localparam logic [2:0] MD_MULT = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV = 3'd3;
    localparam logic [2:0] MD_DIVU = 3'd4;
    localparam logic [2:0] MD_MTHI = 3'd5;
    localparam logic [2:0] MD_MTLO = 3'd6;
    typedef enum logic [1:0] {IDLE, RUN, COMMIT} md_state_e;
endpackage

// File: rtl/md_latency_counter.sv
// md_latency_counter: loadable down-counter; last flags the final RUN cycle (count == 1).
module md_latency_counter
    import md_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk)
        if (reset) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - 1'b1;
    assign last = count == CNT_W'(1);
endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: sequences mult/div/mthi/mtlo from E into the MD unit with one HI/LO write pulse.
// Build option MD_FLUSH_ABORT_EN: flush during RUN/COMMIT aborts the in-flight op.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        flush,
    input  logic        d_md_use,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic [2:0]  md_op,
    output logic        md_we,
    output logic        busy,
    output logic        stall_d
);
    md_state_e state;
    logic [31:0] a_q, b_q;
    logic [2:0] op_q;
    logic take, issue, mt, last, abort;
    logic [CNT_W-1:0] load_val;
`ifdef MD_FLUSH_ABORT_EN
    assign abort = flush;
`else
    assign abort = 1'b0;
`endif
    assign take = state == IDLE && e_valid && !flush;
    assign issue = take && e_op >= MD_MULT && e_op <= MD_DIVU;
    assign mt = take && (e_op == MD_MTHI || e_op == MD_MTLO);
    assign load_val = (e_op == MD_MULT || e_op == MD_MULTU) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
    md_latency_counter u_cnt (
        .clk(clk),
        .reset(reset),
        .load(issue),
        .load_val(load_val),
        .last(last)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            a_q <= '0;
            b_q <= '0;
            op_q <= MD_NONE;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    state <= RUN;
                    a_q <= e_a;
                    b_q <= e_b;
                    op_q <= e_op;
                end
                RUN: state <= abort ? IDLE : last ? COMMIT : RUN;
                default: state <= IDLE;
            endcase
        end
    // Latched values while an op is in flight, live E values in IDLE only for accepted ops
    always_comb begin
        busy = state != IDLE;
        md_a = busy ? a_q : (issue || mt) ? e_a : '0;
        md_b = busy ? b_q : (issue || mt) ? e_b : '0;
        md_op = busy ? op_q : (issue || mt) ? e_op : MD_NONE;
        md_we = mt || (state == COMMIT && !abort);
        stall_d = d_md_use && (busy || issue);
    end
endmodule
